death_digit_renderer: RTL

DEATH_DIGIT_RENDERER -- requirements
Module: death_digit_renderer

---
 rtl/death_digit_renderer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/death_digit_renderer.sv
// Two-digit death counter overlay: snapshots the BCD count on each frame tick,
// renders it as x2-scaled 8x16 glyphs and blinks it for 64 frames after a change.
module death_digit_renderer (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [3:0] tenths,
  input  logic [3:0] ones,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       pixel_on,
  output logic       flashing
);

  // state   | meaning
  // S_IDLE  | digits shown steadily
  // S_FLASH | digits blink 8 frames on / 8 off until 64 frames pass without change
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLASH = 1'b1;

  localparam logic [9:0] X_TENS = 10'd576;
  localparam logic [9:0] X_ONES = 10'd592;
  localparam logic [9:0] Y_TOP  = 10'd16;

  logic       fsync_q, fdly_q;
  logic       fe;
  logic [3:0] snap_t_q, snap_t_d, snap_o_q, snap_o_d;
  logic [0:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       changed;

  logic       in_t, in_o, hide;
  logic [3:0] code_d;
  logic [2:0] col_d;
  logic [3:0] row_d;
  logic       s1_on_d;
  logic       s1_on_q;
  logic [3:0] s1_code_q, s1_row_q;
  logic [2:0] s1_col_q;
  logic [7:0] row_byte;
  logic       pixel_q;

  // Glyph rows packed MSB-first: row 0 is the top byte.
  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [3:0] r);
    logic [127:0] g;
    case (d)
      4'd0:    g = 128'h00007cc6c6cedef6e6c6c67c00000000;
      4'd1:    g = 128'h00001838781818181818187e00000000;
      4'd2:    g = 128'h00007cc6060c183060c0c6fe00000000;
      4'd3:    g = 128'h00007cc606063c060606c67c00000000;
      4'd4:    g = 128'h00000c1c3c6cccfe0c0c0c1e00000000;
      4'd5:    g = 128'h0000fec0c0c0fc060606c67c00000000;
      4'd6:    g = 128'h00003860c0c0fcc6c6c6c67c00000000;
      4'd7:    g = 128'h0000fec606060c183030303000000000;
      4'd8:    g = 128'h00007cc6c6c67cc6c6c6c67c00000000;
      4'd9:    g = 128'h00007cc6c6c67e0606060c7800000000;
      default: g = '0;
    endcase
    font_row = 8'(g >> {~r, 3'b000});
  endfunction

  assign fe       = fsync_q & ~fdly_q;
  assign flashing = (state_q == S_FLASH);
  assign pixel_on = pixel_q;

  always_comb begin
    snap_t_d = snap_t_q;
    snap_o_d = snap_o_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    changed  = ({tenths, ones} != {snap_t_q, snap_o_q});
    if (fe) begin
      snap_t_d = tenths;
      snap_o_d = ones;
      case (state_q)
        S_IDLE: begin
          if (changed) begin
            state_d = S_FLASH;
            cnt_d   = '0;
          end
        end
        default: begin
          if (changed)              cnt_d   = '0;
          else if (cnt_q == 6'd63)  state_d = S_IDLE;
          else                      cnt_d   = cnt_q + 6'd1;
        end
      endcase
    end
  end

  always_comb begin
    in_t   = (DrawY >= Y_TOP) && (DrawY <= 10'd47) && (DrawX >= X_TENS) && (DrawX <= 10'd591);
    in_o   = (DrawY >= Y_TOP) && (DrawY <= 10'd47) && (DrawX >= X_ONES) && (DrawX <= 10'd607);
    code_d = in_o ? snap_o_q : snap_t_q;
    col_d  = 3'((DrawX - (in_o ? X_ONES : X_TENS)) >> 1);
    row_d  = 4'((DrawY - Y_TOP) >> 1);
    hide   = (state_q == S_FLASH) && cnt_q[3];
    // Leading zero on the tens digit and non-BCD codes are blanked here.
    s1_on_d = ((in_t && (snap_t_q != 4'd0)) || in_o) && (code_d <= 4'd9) && !hide;
    row_byte = font_row(s1_code_q, s1_row_q);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fsync_q   <= 1'b0;
      fdly_q    <= 1'b0;
      snap_t_q  <= '0;
      snap_o_q  <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      s1_on_q   <= 1'b0;
      s1_code_q <= '0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
      pixel_q   <= 1'b0;
    end else begin
      fsync_q   <= frame_clk;
      fdly_q    <= fsync_q;
      snap_t_q  <= snap_t_d;
      snap_o_q  <= snap_o_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_on_q   <= s1_on_d;
      s1_code_q <= code_d;
      s1_row_q  <= row_d;
      s1_col_q  <= col_d;
      pixel_q   <= s1_on_q & row_byte[~s1_col_q];
    end
  end

endmodule
